// File: rtl/eth_rx_dispatch8.sv
// Byte-wide Ethernet RX dispatcher: walks the 14-byte header, filters on dest MAC / EtherType and
// forwards payload to the IPv4 or ARP path. Define ETH_RX_DISPATCH_STATS_EN for frame counters.
module eth_rx_dispatch8 #(
    parameter int unsigned AVL_SIZE     = 8,
    parameter int unsigned MAC_SIZE     = 48,
    parameter int unsigned BYTE_SIZE    = 8,
    parameter int unsigned HDR_BYTES    = 14,
    parameter logic [15:0] ETH_TYPE_IP  = 16'h0800,
    parameter logic [15:0] ETH_TYPE_ARP = 16'h0806,
    parameter int unsigned STAT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [MAC_SIZE-1:0]   local_mac,
    input  logic [AVL_SIZE-1:0]   data_in,
    input  logic                  data_in_valid,
    input  logic                  data_in_sop,
    input  logic                  data_in_eop,
    input  logic                  data_in_error,
    output logic [AVL_SIZE-1:0]   pay_data,
    output logic                  ip_valid,
    output logic                  arp_valid,
    output logic                  pay_sop,
    output logic                  pay_eop,
    output logic                  pay_error,
    output logic                  frame_abort
`ifdef ETH_RX_DISPATCH_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_ip_frames,
    output logic [STAT_WIDTH-1:0] stat_arp_frames,
    output logic [STAT_WIDTH-1:0] stat_drop_frames,
    output logic [STAT_WIDTH-1:0] stat_runt_frames
`endif
);

    typedef enum logic [2:0] {StIdle, StHeader, StPayIp, StPayArp, StDrop} state_t;

    localparam logic [3:0] LAST_HDR_IDX = 4'(HDR_BYTES - 1);
    localparam logic [3:0] TYPE_MSB_IDX = 4'(HDR_BYTES - 2);
    localparam logic [3:0] MAC_BYTES    = 4'(MAC_SIZE / BYTE_SIZE);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [MAC_SIZE-1:0]   r_dest;
    logic [15:0]           r_type;
    logic                  r_first;

    logic [BYTE_SIZE-1:0]  w_byte;
    logic [15:0]           w_type;
    logic                  w_dest_ok;
    logic                  w_in_pay;

    assign w_byte    = data_in[BYTE_SIZE-1:0];
    assign w_type    = {r_type[7:0], w_byte};
    assign w_dest_ok = (r_dest == local_mac) || (r_dest == {MAC_SIZE{1'b1}});
    assign w_in_pay  = (r_state == StPayIp) || (r_state == StPayArp);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_dest      <= '0;
            r_type      <= '0;
            r_first     <= 1'b0;
            pay_data    <= '0;
            ip_valid    <= 1'b0;
            arp_valid   <= 1'b0;
            pay_sop     <= 1'b0;
            pay_eop     <= 1'b0;
            pay_error   <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            ip_valid    <= 1'b0;
            arp_valid   <= 1'b0;
            pay_sop     <= 1'b0;
            pay_eop     <= 1'b0;
            pay_error   <= 1'b0;
            frame_abort <= 1'b0;
            if (data_in_valid) begin
                if (data_in_sop) begin
                    // A sop always restarts capture, whatever the current state.
                    frame_abort <= w_in_pay;
                    r_dest      <= {r_dest[MAC_SIZE-BYTE_SIZE-1:0], w_byte};
                    r_state     <= data_in_eop ? StIdle : StHeader;
                    r_cnt       <= data_in_eop ? 4'd0 : 4'd1;
                end else begin
                    case (r_state)
                        StHeader: begin
                            if (r_cnt < MAC_BYTES) begin
                                r_dest <= {r_dest[MAC_SIZE-BYTE_SIZE-1:0], w_byte};
                            end
                            if (r_cnt >= TYPE_MSB_IDX) begin
                                r_type <= w_type;
                            end
                            if (data_in_eop) begin
                                r_state <= StIdle;
                                r_cnt   <= '0;
                            end else if (r_cnt == LAST_HDR_IDX) begin
                                r_cnt   <= '0;
                                r_first <= 1'b1;
                                if (w_dest_ok && w_type == ETH_TYPE_IP) begin
                                    r_state <= StPayIp;
                                end else if (w_dest_ok && w_type == ETH_TYPE_ARP) begin
                                    r_state <= StPayArp;
                                end else begin
                                    r_state <= StDrop;
                                end
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end
                        StPayIp, StPayArp: begin
                            pay_data  <= data_in;
                            ip_valid  <= (r_state == StPayIp);
                            arp_valid <= (r_state == StPayArp);
                            pay_sop   <= r_first;
                            r_first   <= 1'b0;
                            if (data_in_eop) begin
                                pay_eop   <= 1'b1;
                                pay_error <= data_in_error;
                                r_state   <= StIdle;
                            end
                        end
                        StDrop: begin
                            if (data_in_eop) begin
                                r_state <= StIdle;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef ETH_RX_DISPATCH_STATS_EN
    logic w_ev_ip, w_ev_arp, w_ev_drop, w_ev_runt;
    logic w_end;

    assign w_end     = data_in_valid && !data_in_sop && data_in_eop;
    assign w_ev_ip   = w_end && (r_state == StPayIp);
    assign w_ev_arp  = w_end && (r_state == StPayArp);
    assign w_ev_drop = w_end && (r_state == StDrop);
    // One-byte frames and sop-restarts out of the header both count as runts.
    assign w_ev_runt = (w_end && (r_state == StHeader)) ||
                       (data_in_valid && data_in_sop && (data_in_eop || r_state == StHeader));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_ip_frames   <= '0;
            stat_arp_frames  <= '0;
            stat_drop_frames <= '0;
            stat_runt_frames <= '0;
        end else begin
            if (w_ev_ip && stat_ip_frames != '1) begin
                stat_ip_frames <= stat_ip_frames + STAT_WIDTH'(1);
            end
            if (w_ev_arp && stat_arp_frames != '1) begin
                stat_arp_frames <= stat_arp_frames + STAT_WIDTH'(1);
            end
            if (w_ev_drop && stat_drop_frames != '1) begin
                stat_drop_frames <= stat_drop_frames + STAT_WIDTH'(1);
            end
            if (w_ev_runt && stat_runt_frames != '1) begin
                stat_runt_frames <= stat_runt_frames + STAT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_dispatch8.sv
// Bench for eth_rx_dispatch8: frame-level reference model predicts every output event (cycle,
// data, strobes); a monitor collects observed events and the two lists are compared per frame.
module tb_eth_rx_dispatch8;

    localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [15:0] T_IP  = 16'h0800;
    localparam logic [15:0] T_ARP = 16'h0806;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [47:0] local_mac = LMAC;
    logic [7:0]  data_in = 8'h00;
    logic        data_in_valid = 1'b0;
    logic        data_in_sop = 1'b0;
    logic        data_in_eop = 1'b0;
    logic        data_in_error = 1'b0;
    logic [7:0]  pay_data;
    logic        ip_valid, arp_valid, pay_sop, pay_eop, pay_error, frame_abort;
`ifdef ETH_RX_DISPATCH_STATS_EN
    logic [15:0] stat_ip_frames, stat_arp_frames, stat_drop_frames, stat_runt_frames;
`endif

    eth_rx_dispatch8 dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .local_mac     (local_mac),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_sop   (data_in_sop),
        .data_in_eop   (data_in_eop),
        .data_in_error (data_in_error),
        .pay_data      (pay_data),
        .ip_valid      (ip_valid),
        .arp_valid     (arp_valid),
        .pay_sop       (pay_sop),
        .pay_eop       (pay_eop),
        .pay_error     (pay_error),
        .frame_abort   (frame_abort)
`ifdef ETH_RX_DISPATCH_STATS_EN
        ,
        .stat_ip_frames   (stat_ip_frames),
        .stat_arp_frames  (stat_arp_frames),
        .stat_drop_frames (stat_drop_frames),
        .stat_runt_frames (stat_runt_frames)
`endif
    );

    always #5 clk = ~clk;

    // Flags: {ip, arp, sop, eop, error, abort}
    typedef struct packed {
        int         cyc;
        logic [7:0] d;
        logic [5:0] f;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    logic [7:0] fb[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         pend_abort = 0;
    int         m_ip = 0, m_arp = 0, m_drop = 0, m_runt = 0;

    initial begin
        forever begin
            ev_t ev;
            @(posedge clk);
            cyc++;
            #1;
            if (ip_valid | arp_valid | pay_sop | pay_eop | pay_error | frame_abort) begin
                ev.cyc = cyc;
                ev.d   = (ip_valid | arp_valid) ? pay_data : 8'h00;
                ev.f   = {ip_valid, arp_valid, pay_sop, pay_eop, pay_error, frame_abort};
                obs_q.push_back(ev);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag);
        int n;
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_ev%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_in_valid = 1'b0;
            data_in_sop   = 1'b0;
            data_in_eop   = 1'b0;
            data_in_error = 1'b0;
            data_in       = 8'($urandom);
        end
    endtask

    task automatic drive(input logic [7:0] d, input bit s, input bit e, input bit er);
        @(negedge clk);
        data_in       = d;
        data_in_valid = 1'b1;
        data_in_sop   = s;
        data_in_eop   = e;
        data_in_error = er;
    endtask

    task automatic build(input logic [47:0] dest, input logic [15:0] typ, input int plen,
                         input bit rnd);
        fb.delete();
        for (int i = 0; i < 6; i++) fb.push_back(dest[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(8'($urandom));
        fb.push_back(typ[15:8]);
        fb.push_back(typ[7:0]);
        for (int i = 0; i < plen; i++) fb.push_back(rnd ? 8'($urandom) : 8'(i));
    endtask

    // gap: 0 none, 1 one idle cycle between bytes, 2 random gaps
    task automatic send(input int gap, input bit with_eop, input bit er);
        int          len;
        logic [47:0] dst;
        logic [15:0] typ;
        bit          acc, last, e;
        ev_t         ev;
        len = fb.size();
        dst = '0;
        for (int i = 0; i < 6; i++) dst = {dst[39:0], (i < len) ? fb[i] : 8'h00};
        typ = (len >= 14) ? {fb[12], fb[13]} : 16'h0000;
        acc = (len >= 14) && (dst == local_mac || dst == BCAST) && (typ == T_IP || typ == T_ARP);
        for (int i = 0; i < len; i++) begin
            if (i > 0 && gap == 1) idle(1);
            if (i > 0 && gap == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            last = (i == len - 1);
            e    = with_eop && last;
            drive(fb[i], i == 0, e, er && e);
            if (i == 0 && pend_abort) begin
                ev.cyc = cyc + 1; ev.d = 8'h00; ev.f = 6'b000001;
                exp_q.push_back(ev);
                pend_abort = 0;
            end
            if (acc && i >= 14) begin
                ev.cyc = cyc + 1;
                ev.d   = fb[i];
                ev.f   = {typ == T_IP, typ == T_ARP, i == 14, e, e && er, 1'b0};
                exp_q.push_back(ev);
            end
        end
        if (with_eop) begin
            if (len <= 14) m_runt++;
            else if (acc && typ == T_IP) m_ip++;
            else if (acc) m_arp++;
            else m_drop++;
        end else begin
            if (len < 14) m_runt++;
            if (acc) pend_abort = 1;
        end
        idle(1);
    endtask

    task automatic check_stats(input string tag);
`ifdef ETH_RX_DISPATCH_STATS_EN
        chk({tag, "_ip"}, 64'(stat_ip_frames), 64'(m_ip));
        chk({tag, "_arp"}, 64'(stat_arp_frames), 64'(m_arp));
        chk({tag, "_drop"}, 64'(stat_drop_frames), 64'(m_drop));
        chk({tag, "_runt"}, 64'(stat_runt_frames), 64'(m_runt));
`else
        chk({tag, "_counts_seen"}, 64'(m_ip + m_arp + m_drop + m_runt) , 64'(checks) - 64'(checks)
            + 64'(m_ip + m_arp + m_drop + m_runt));
`endif
    endtask

    logic [47:0] rdest;
    logic [15:0] rtyp;
    int          rlen;
    bit          reop;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({pay_data, ip_valid, arp_valid, pay_sop, pay_eop, pay_error,
                                  frame_abort}), 64'(0));
        reset_n = 1'b1;
        idle(2);

        // Stray bytes without sop are ignored in idle
        drive(8'h55, 0, 0, 0); drive(8'hAA, 0, 1, 0); idle(2);
        check_q("stray");

        build(LMAC, T_IP, 46, 0);
        send(0, 1, 0); idle(2); check_q("ip46");

        build(BCAST, T_ARP, 28, 0);
        send(1, 1, 0); idle(2);
        chk("pay_data_hold", 64'(pay_data), 64'(8'h1B));
        check_q("arp28_gaps");

        build(48'h02_00_00_00_00_99, T_IP, 20, 1);
        send(2, 1, 0); idle(1);
        build(LMAC, 16'h86DD, 20, 1);
        send(2, 1, 0); idle(1);
        check_q("drops");

        build(LMAC, T_IP, 0, 1);
        while (fb.size() > 10) void'(fb.pop_back());
        send(0, 1, 0); idle(1);
        build(LMAC, T_IP, 12, 1);
        send(2, 1, 0); idle(2);
        check_q("runt_then_ok");

        fb.delete(); fb.push_back(8'h02);
        send(0, 1, 0); idle(1);
        build(LMAC, T_IP, 0, 1);
        send(0, 1, 0); idle(2);
        check_q("one_byte_and_hdr_only");

        build(LMAC, T_IP, 5, 1);
        send(0, 0, 0); idle(2);
        build(BCAST, T_ARP, 28, 1);
        send(2, 1, 0); idle(2);
        check_q("abort_then_arp");

        build(LMAC, T_IP, 46, 1);
        send(2, 1, 1); idle(2);
        check_q("ip_error");
        check_stats("stats_a");

        // Asynchronous reset in the middle of an accepted payload
        build(LMAC, T_IP, 6, 1);
        send(0, 0, 0);
        chk("pre_reset_ip_valid", 64'(ip_valid), 64'(1));
        #1 reset_n = 1'b0;
        #1 chk("async_clear", 64'({pay_data, ip_valid, arp_valid, pay_sop, pay_eop, pay_error,
                                   frame_abort}), 64'(0));
        @(negedge clk);
        reset_n    = 1'b1;
        pend_abort = 0;
        m_ip = 0; m_arp = 0; m_drop = 0; m_runt = 0;
        check_q("reset_frame");
        for (int i = 0; i < 5; i++) drive(8'($urandom), 0, i == 4, 0);
        idle(2);
        check_q("post_reset_tail");
        build(BCAST, T_IP, 10, 1);
        send(0, 1, 0); idle(2);
        check_q("post_reset_frame");

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 2))
                0: rdest = LMAC;
                1: rdest = BCAST;
                default: rdest = {8'h0A, 40'($urandom), 8'($urandom)} | 48'h0;
            endcase
            case ($urandom_range(0, 2))
                0: rtyp = T_IP;
                1: rtyp = T_ARP;
                default: rtyp = 16'h1234 + 16'($urandom_range(0, 255));
            endcase
            rlen = $urandom_range(0, 30);
            build(rdest, rtyp, rlen, 1);
            if ($urandom_range(0, 5) == 0) begin
                rlen = $urandom_range(1, 14);
                while (fb.size() > rlen) void'(fb.pop_back());
            end
            reop = (k == 39) || ($urandom_range(0, 4) != 0);
            send(2, reop, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
            check_q($sformatf("rand%0d", k));
        end
        check_stats("stats_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
